rv_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32 pipeline.
- Owns the fetch PC and drives a single-outstanding instruction-bus request.
- Presents the instruction/PC pair to the decode register.
- Consumes the hazard controller's fetch stall and the execute-stage redirect (pc_sel/target).
- Produces the "instruction available" indication the controller uses as its fetch bus acknowledge.

---
 rtl/rv_fetch_pkg.sv | 41 ++++
 rtl/rv_fetch_skid.sv | 52 +++++
 rtl/rv_fetch.sv | 183 ++++++++++++++++++
 tb/tb_rv_fetch.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// ============================================================================
//  Module      : rv_fetch_pkg
//  Description : Shared types and constants for the RV32 instruction-fetch
//                stage: NOP encoding, fetch FSM state encoding, the
//                instruction/PC pair carried through the skid buffer and
//                small PC helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_fetch_pkg;

    // Canonical RV32 NOP (addi x0, x0, 0) shown on the output after reset.
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Fetch FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        FETCH_S_REQ     = 2'b00,  // request outstanding / issuing at the fetch PC
        FETCH_S_HOLD    = 2'b01,  // output and skid both occupied, bus idle
        FETCH_S_DISCARD = 2'b10   // waiting out a response made stale by a redirect
    } fetch_state_e;

    // Instruction word together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_pair_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential next PC; wraps modulo 2^32 without any special handling.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : rv_fetch_pkg

`default_nettype wire

// File: rtl/rv_fetch_skid.sv
// ============================================================================
//  Module      : rv_fetch_skid
//  Description : One-entry {instr, pc} skid buffer for the fetch stage.
//                Captures a bus response that arrives while the output
//                register is stalled. Clear has priority over load, load over
//                drain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_fetch_skid
    import rv_fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_clear,
    input  fetch_pair_t i_data,
    output logic        o_full,
    output fetch_pair_t o_data
);

    logic        full_q;
    fetch_pair_t data_q;

    // Occupancy flag: a redirect or reset empties the entry immediately.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            full_q <= 1'b0;
        end else if (i_load) begin
            full_q <= 1'b1;
        end else if (i_drain) begin
            full_q <= 1'b0;
        end
    end

    // Payload storage; contents only matter while full_q is set.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            data_q <= '0;
        end else if (i_load && !i_clear) begin
            data_q <= i_data;
        end
    end

    assign o_full = full_q;
    assign o_data = data_q;

endmodule : rv_fetch_skid

`default_nettype wire

// File: rtl/rv_fetch.sv
// ============================================================================
//  Module      : rv_fetch
//  Description : Instruction-fetch stage of the 5-stage RV32 pipeline. Owns
//                the fetch PC, drives a single-outstanding instruction bus
//                request, and presents {instr, pc} to the decode register.
//                Honours the hazard controller's stall and the execute-stage
//                redirect, which takes priority over both stall and ack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stall,
    input  logic        i_pc_sel,
    input  logic [31:0] i_pc_target,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q,    pc_d;      // address of the next fresh fetch
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  opc_q,   opc_d;     // PC of the instruction on the output
    logic         req_q,   req_d;
    logic [31:0]  addr_q,  addr_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_ack;
    logic        w_skid_load;
    logic        w_skid_drain;
    logic        w_skid_clear;
    logic        w_skid_full;
    fetch_pair_t w_skid_in;
    fetch_pair_t w_skid_out;
    logic        w_unused_target_lsbs;

    // The output register can take a new instruction when empty or not stalled.
    assign w_accept  = !valid_q || !i_stall;

    // A response only counts while our request is actually on the bus; this
    // also discards a stray ack in the idle cycle right after reset.
    assign w_ack     = i_bus_ack && req_q;

    assign w_skid_in = '{instr: i_bus_rdata, pc: pc_q};

    // Target bits [1:0] are dropped by word_align.
    assign w_unused_target_lsbs = ^i_pc_target[1:0];

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    rv_fetch_skid u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (w_skid_load),
        .i_drain   (w_skid_drain),
        .i_clear   (w_skid_clear),
        .i_data    (w_skid_in),
        .o_full    (w_skid_full),
        .o_data    (w_skid_out)
    );

    // Next-state, next-PC and output-register decisions; redirect wins over everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        w_skid_load  = 1'b0;
        w_skid_drain = 1'b0;
        w_skid_clear = 1'b0;

        if (i_pc_sel) begin
            // Squash everything in flight and restart at the target. If a
            // request is still waiting for its response, that response must
            // be absorbed before a new request can go out.
            valid_d      = 1'b0;
            w_skid_clear = 1'b1;
            pc_d         = word_align(i_pc_target);
            if (((state_q == FETCH_S_REQ) && req_q && !w_ack) ||
                ((state_q == FETCH_S_DISCARD) && !w_ack)) begin
                state_d = FETCH_S_DISCARD;
            end else begin
                state_d = FETCH_S_REQ;
            end
        end else begin
            case (state_q)
                FETCH_S_REQ: begin
                    if (w_ack) begin
                        pc_d = pc_inc(pc_q);
                        if (w_accept) begin
                            instr_d = i_bus_rdata;
                            opc_d   = pc_q;
                            valid_d = 1'b1;
                        end else begin
                            // Output is stalled and full: park the response.
                            w_skid_load = 1'b1;
                            state_d     = FETCH_S_HOLD;
                        end
                    end else if (w_accept) begin
                        valid_d = 1'b0;
                    end
                end
                FETCH_S_HOLD: begin
                    if (!i_stall) begin
                        instr_d      = w_skid_out.instr;
                        opc_d        = w_skid_out.pc;
                        valid_d      = w_skid_full;
                        w_skid_drain = 1'b1;
                        state_d      = FETCH_S_REQ;
                    end
                end
                FETCH_S_DISCARD: begin
                    valid_d = 1'b0;
                    if (w_ack) begin
                        state_d = FETCH_S_REQ;
                    end
                end
                default: begin
                    state_d = FETCH_S_REQ;
                end
            endcase
        end
    end

    // Bus outputs follow the next state so they are registered. In DISCARD
    // the stale address is held until its response arrives; otherwise the
    // bus presents the fetch PC.
    always_comb begin
        req_d  = (state_d != FETCH_S_HOLD);
        addr_d = (state_d == FETCH_S_DISCARD) ? addr_q : pc_d;
    end

    // FSM, PC, bus and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= FETCH_S_REQ;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            instr_q <= RV_NOP;
            opc_q   <= RESET_VECTOR;
            req_q   <= 1'b0;
            addr_q  <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign o_bus_req  = req_q;
    assign o_bus_addr = addr_q;
    assign o_valid    = valid_q;
    assign o_instr    = instr_q;
    assign o_pc       = opc_q;

endmodule : rv_fetch

`default_nettype wire

// File: tb/tb_rv_fetch.sv
// ============================================================================
//  Module      : tb_rv_fetch
//  Description : Self-checking bench for rv_fetch. Directed scenario tasks
//                plus a randomized run, with a cycle monitor comparing the
//                DUT against a queue-based model of the fetch stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_fetch;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_pc_sel = 1'b0;
    logic [31:0] i_pc_target = 32'h0;
    logic        o_bus_req;
    logic [31:0] o_bus_addr;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = 32'h0;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    int checks   = 0;
    int failures = 0;

    rv_fetch #(.RESET_VECTOR(RV)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_stall     (i_stall),
        .i_pc_sel    (i_pc_sel),
        .i_pc_target (i_pc_target),
        .o_bus_req   (o_bus_req),
        .o_bus_addr  (o_bus_addr),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata),
        .o_valid     (o_valid),
        .o_instr     (o_instr),
        .o_pc        (o_pc)
    );

    always #5 i_clk = ~i_clk;

    // Memory contents: a bijective scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) * 32'h0001_0003 + 32'h0000_0013;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: the list of fetched-but-not-consumed PCs in order,
    // the next PC to fetch, and whether a stale response is still due.
    // ------------------------------------------------------------------
    logic [31:0] m_q[$];
    logic [31:0] m_nf        = RV;
    logic        m_disc      = 1'b0;
    logic [31:0] m_disc_addr = 32'h0;
    logic        m_prev_req  = 1'b0;
    logic        m_prev_ack  = 1'b0;
    logic [31:0] m_prev_addr = 32'h0;

    always @(negedge i_clk) begin : monitor
        logic        ack;
        logic [31:0] exp_addr;
        ack = i_bus_ack & o_bus_req;
        if (!i_reset_n) begin
            m_q.delete();
            m_nf       = RV;
            m_disc     = 1'b0;
            m_prev_req = 1'b0;
            m_prev_ack = 1'b0;
        end else begin
            checks++;
            if (o_valid !== (m_q.size() != 0)) begin
                failures++;
                $display("FAIL mon_valid t=%0t: got %b expected %b", $time, o_valid, (m_q.size() != 0));
            end
            if (m_q.size() != 0) begin
                checks++;
                if (o_pc !== m_q[0] || o_instr !== mem_word(m_q[0])) begin
                    failures++;
                    $display("FAIL mon_output t=%0t: got pc=%h instr=%h expected pc=%h instr=%h",
                             $time, o_pc, o_instr, m_q[0], mem_word(m_q[0]));
                end
            end
            if (o_bus_req === 1'b1) begin
                exp_addr = m_disc ? m_disc_addr : m_nf;
                checks++;
                if (o_bus_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL mon_addr t=%0t: got %h expected %h", $time, o_bus_addr, exp_addr);
                end
            end
            if (m_q.size() >= 2) begin
                checks++;
                if (o_bus_req !== 1'b0) begin
                    failures++;
                    $display("FAIL mon_full_req t=%0t: got req=%b expected 0", $time, o_bus_req);
                end
            end
            if (m_prev_req && !m_prev_ack) begin
                checks++;
                if (o_bus_req !== 1'b1 || o_bus_addr !== m_prev_addr) begin
                    failures++;
                    $display("FAIL mon_stable t=%0t: got req=%b addr=%h expected req=1 addr=%h",
                             $time, o_bus_req, o_bus_addr, m_prev_addr);
                end
            end
            // Advance the model to what the next cycle should show.
            if (i_pc_sel) begin
                m_q.delete();
                if (ack) begin
                    m_disc = 1'b0;
                end else if (o_bus_req) begin
                    if (!m_disc) m_disc_addr = o_bus_addr;
                    m_disc = 1'b1;
                end
                m_nf = {i_pc_target[31:2], 2'b00};
            end else begin
                if (m_q.size() != 0 && !i_stall) void'(m_q.pop_front());
                if (ack) begin
                    if (m_disc) begin
                        m_disc = 1'b0;
                    end else begin
                        m_q.push_back(m_nf);
                        m_nf = m_nf + 32'd4;
                    end
                end
            end
            m_prev_req  = o_bus_req;
            m_prev_ack  = ack;
            m_prev_addr = o_bus_addr;
        end
    end

    // One cycle of stimulus; returns at the following negedge.
    // ack_mode: 0 = no ack, 1 = ack if requested, 2 = ack regardless (stray).
    task automatic step(input logic rst_n, input logic stall, input logic sel,
                        input logic [31:0] tgt, input int ack_mode);
        @(posedge i_clk);
        #1;
        i_reset_n   = rst_n;
        i_stall     = stall;
        i_pc_sel    = sel;
        i_pc_target = tgt;
        i_bus_ack   = (ack_mode == 2) || ((ack_mode == 1) && o_bus_req);
        i_bus_rdata = i_bus_ack ? mem_word(o_bus_addr) : $urandom;
        @(negedge i_clk);
    endtask

    // Two reset cycles then the idle release cycle; next step is the first request.
    task automatic reset_and_release();
        step(1'b0, 1'b0, 1'b0, 32'h0, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_bus_req !== 1'b0 || o_valid !== 1'b0 || o_instr !== NOP || o_pc !== RV) begin
            failures++;
            $display("FAIL reset_values: got req=%b valid=%b instr=%h pc=%h expected 0 0 %h %h",
                     o_bus_req, o_valid, o_instr, o_pc, NOP, RV);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 2);
        checks++;
        if (o_bus_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got req=%b expected 0", o_bus_req);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_bus_req !== 1'b1 || o_bus_addr !== RV || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_req: got req=%b addr=%h valid=%b expected 1 %h 0",
                     o_bus_req, o_bus_addr, o_valid, RV);
        end
    endtask

    task automatic test_stream();
        reset_and_release();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1);
            checks++;
            if (o_bus_req !== 1'b1 || o_bus_addr !== 32'(4 * i)) begin
                failures++;
                $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected 1 %h",
                         i, o_bus_req, o_bus_addr, 32'(4 * i));
            end
            if (i > 0) begin
                checks++;
                if (o_valid !== 1'b1 || o_pc !== 32'(4 * (i - 1)) || o_instr !== mem_word(32'(4 * (i - 1)))) begin
                    failures++;
                    $display("FAIL stream_out[%0d]: got valid=%b pc=%h instr=%h expected 1 %h %h",
                             i, o_valid, o_pc, o_instr, 32'(4 * (i - 1)), mem_word(32'(4 * (i - 1))));
                end
            end
        end
    endtask

    task automatic test_stall();
        reset_and_release();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        checks++;
        if (o_bus_addr !== 32'h8 || o_pc !== 32'h4 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_entry: got addr=%h pc=%h valid=%b expected 8 4 1", o_bus_addr, o_pc, o_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1);
            checks++;
            if (o_bus_req !== 1'b0 || o_valid !== 1'b1 || o_pc !== 32'h4 || o_instr !== mem_word(32'h4)) begin
                failures++;
                $display("FAIL stall_frozen[%0d]: got req=%b valid=%b pc=%h instr=%h expected 0 1 4 %h",
                         i, o_bus_req, o_valid, o_pc, o_instr, mem_word(32'h4));
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (o_bus_req !== 1'b0 || o_pc !== 32'h4) begin
            failures++;
            $display("FAIL stall_release: got req=%b pc=%h expected 0 4", o_bus_req, o_pc);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (o_pc !== 32'h8 || o_instr !== mem_word(32'h8) || o_bus_req !== 1'b1 || o_bus_addr !== 32'hC) begin
            failures++;
            $display("FAIL stall_resume: got pc=%h instr=%h req=%b addr=%h expected 8 %h 1 c",
                     o_pc, o_instr, o_bus_req, o_bus_addr, mem_word(32'h8));
        end
    endtask

    task automatic test_redirect_discard();
        reset_and_release();
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 1'b1, 32'h103, 0);
        checks++;
        if (o_bus_addr !== 32'h10 || o_valid !== 1'b1 || o_pc !== 32'hC) begin
            failures++;
            $display("FAIL redir_pre: got addr=%h valid=%b pc=%h expected 10 1 c", o_bus_addr, o_valid, o_pc);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h10 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_discard_wait: got req=%b addr=%h valid=%b expected 1 10 0", o_bus_req, o_bus_addr, o_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (o_bus_addr !== 32'h10 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_discard_ack: got addr=%h valid=%b expected 10 0", o_bus_addr, o_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h100 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_target_req: got req=%b addr=%h valid=%b expected 1 100 0", o_bus_req, o_bus_addr, o_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== mem_word(32'h100) || o_bus_addr !== 32'h104) begin
            failures++;
            $display("FAIL redir_target_out: got valid=%b pc=%h instr=%h addr=%h expected 1 100 %h 104",
                     o_valid, o_pc, o_instr, o_bus_addr, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_stall_ack();
        reset_and_release();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b1, 1'b1, 32'h40, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (o_valid !== 1'b0 || o_bus_req !== 1'b1 || o_bus_addr !== 32'h40) begin
            failures++;
            $display("FAIL redir_stall_ack: got valid=%b req=%b addr=%h expected 0 1 40", o_valid, o_bus_req, o_bus_addr);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_instr !== mem_word(32'h40)) begin
            failures++;
            $display("FAIL redir_stall_out: got valid=%b pc=%h instr=%h expected 1 40 %h", o_valid, o_pc, o_instr, mem_word(32'h40));
        end
    endtask

    task automatic test_wrap();
        reset_and_release();
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (o_bus_addr !== 32'hFFFF_FFF8 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_align: got addr=%h valid=%b expected fffffff8 0", o_bus_addr, o_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (o_bus_addr !== 32'h0 || o_pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_addr: got addr=%h pc=%h expected 0 fffffffc", o_bus_addr, o_pc);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_pc !== 32'h0 || o_instr !== mem_word(32'h0) || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_out: got pc=%h instr=%h valid=%b expected 0 %h 1", o_pc, o_instr, o_valid, mem_word(32'h0));
        end
    endtask

    task automatic test_reset_in_discard();
        reset_and_release();
        step(1'b1, 1'b0, 1'b1, 32'h200, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_disc_state: got req=%b addr=%h valid=%b expected 1 0 0", o_bus_req, o_bus_addr, o_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 2);
        checks++;
        if (o_bus_req !== 1'b0 || o_valid !== 1'b0 || o_instr !== NOP || o_pc !== RV) begin
            failures++;
            $display("FAIL rst_disc_values: got req=%b valid=%b instr=%h pc=%h expected 0 0 %h %h",
                     o_bus_req, o_valid, o_instr, o_pc, NOP, RV);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_bus_req !== 1'b1 || o_bus_addr !== RV || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_disc_first_req: got req=%b addr=%h valid=%b expected 1 %h 0", o_bus_req, o_bus_addr, o_valid, RV);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (o_valid !== 1'b0 || o_bus_addr !== RV) begin
            failures++;
            $display("FAIL rst_disc_stray: got valid=%b addr=%h expected 0 %h", o_valid, o_bus_addr, RV);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== RV || o_instr !== mem_word(RV)) begin
            failures++;
            $display("FAIL rst_disc_out: got valid=%b pc=%h instr=%h expected 1 %h %h", o_valid, o_pc, o_instr, RV, mem_word(RV));
        end
    endtask

    task automatic test_random();
        logic        rst_n;
        logic        stall;
        logic        sel;
        logic [31:0] tgt;
        int          ack_mode;
        reset_and_release();
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(199) != 0);
            stall    = ($urandom_range(99) < 30);
            sel      = ($urandom_range(99) < 5);
            tgt      = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            ack_mode = ($urandom_range(99) < 60) ? 1 : 0;
            step(rst_n, stall, sel, tgt, ack_mode);
        end
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (o_bus_req !== 1'b1 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL random_throughput: got req=%b valid=%b expected 1 1", o_bus_req, o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_discard();
        test_redirect_stall_ack();
        test_wrap();
        test_reset_in_discard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_rv_fetch

`default_nettype wire
